// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
// req/gnt/rvalid handshake, at most one outstanding word read.
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over the imem bus, feeds the IF/ID register.
// Optional macro IF_MISALIGN_CHK_EN aligns jump targets and flags misaligned ones on if2cu_misalign_o.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic                  cu2if_jump_flag_i,
  input  logic [31:0]           cu2if_jump_addr_i,
  input  logic                  cu2if_hold_flag_i,
  if_fetch_unit_if.master       imem,
`ifdef IF_MISALIGN_CHK_EN
  output logic                  if2cu_misalign_o,
`endif
  output logic [31:0]           if2ifid_addr_o,
  output logic [31:0]           if2ifid_ins_o,
  output logic                  if2ifid_valid_o
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_DROP  = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic [31:0] out_ins_q, out_ins_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_ins_q, buf_ins_d;
  logic        mis_q, mis_d;
  logic [31:0] jump_tgt_s;
  logic        jump_mis_s;

`ifdef IF_MISALIGN_CHK_EN
  assign jump_tgt_s = {cu2if_jump_addr_i[31:2], 2'b00};
  assign jump_mis_s = (cu2if_jump_addr_i[1:0] != 2'b00);
  assign if2cu_misalign_o = mis_q;
`else
  assign jump_tgt_s = cu2if_jump_addr_i;
  assign jump_mis_s = 1'b0;
`endif

  // Next-state logic: jump beats hold beats normal flow.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_addr_d  = out_addr_q;
    out_ins_d   = out_ins_q;
    out_valid_d = out_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_ins_d   = buf_ins_q;
    mis_d       = 1'b0;

    if (cu2if_jump_flag_i) begin
      pc_d        = jump_tgt_s;
      mis_d       = jump_mis_s;
      out_addr_d  = 32'h0000_0000;
      out_ins_d   = NOP_INS;
      out_valid_d = 1'b0;
      buf_addr_d  = 32'h0000_0000;
      buf_ins_d   = 32'h0000_0000;
      // An in-flight or just-granted read still owes one response that must be discarded.
      case (state_q)
        S_FETCH: state_d = imem.gnt    ? S_DROP  : S_FETCH;
        S_WAIT:  state_d = imem.rvalid ? S_FETCH : S_DROP;
        S_DROP:  state_d = imem.rvalid ? S_FETCH : S_DROP;
        default: state_d = S_FETCH;
      endcase
    end else begin
      if (!cu2if_hold_flag_i) begin
        out_addr_d  = 32'h0000_0000;
        out_ins_d   = NOP_INS;
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end

      case (state_q)
        S_RESET: state_d = S_FETCH;
        S_FETCH: state_d = imem.gnt ? S_WAIT : S_FETCH;
        S_WAIT: begin
          if (imem.rvalid && cu2if_hold_flag_i) begin
            buf_addr_d = pc_q;
            buf_ins_d  = imem.rdata;
            state_d    = S_HOLD;
          end else if (imem.rvalid) begin
            out_addr_d  = pc_q;
            out_ins_d   = imem.rdata;
            out_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
            state_d     = S_FETCH;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          if (!cu2if_hold_flag_i) begin
            out_addr_d  = buf_addr_q;
            out_ins_d   = buf_ins_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
            state_d     = S_FETCH;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_DROP:  state_d = imem.rvalid ? S_FETCH : S_DROP;
        default: state_d = S_RESET;
      endcase
    end

    req_d = (state_d == S_FETCH);
  end

  // State, PC, skid buffer and all registered outputs.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q     <= S_RESET;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      out_addr_q  <= 32'h0000_0000;
      out_ins_q   <= NOP_INS;
      out_valid_q <= 1'b0;
      buf_addr_q  <= 32'h0000_0000;
      buf_ins_q   <= 32'h0000_0000;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      out_addr_q  <= out_addr_d;
      out_ins_q   <= out_ins_d;
      out_valid_q <= out_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_ins_q   <= buf_ins_d;
      mis_q       <= mis_d;
    end
  end

  assign imem.req        = req_q;
  assign imem.addr       = pc_q;
  assign if2ifid_addr_o  = out_addr_q;
  assign if2ifid_ins_o   = out_ins_q;
  assign if2ifid_valid_o = out_valid_q;

endmodule
